// File: rtl/fir_pkg.sv
// Shared definitions for the 1-2-1 FIR filter and its deconvolver:
// default widths, tap constants and FSM state encodings.
package fir_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int Y_W_DEF    = 16;
    localparam int CNT_W_DEF  = 16;

    // Leading tap is 1, so the inverse needs no division.
    localparam int TAP0 = 1;
    localparam int TAP1 = 2;
    localparam int TAP2 = 1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_ERR  = 2'd2;

endpackage

// File: rtl/fir_deconv_core.sv
// Combinational inverse of the 1-2-1 FIR: x = y - 2*x1 - x2,
// evaluated at full signed width, with a range check on the result.
module fir_deconv_core
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int Y_W    = Y_W_DEF
) (
    input  logic [Y_W-1:0]    y,
    input  logic [DATA_W-1:0] h1,
    input  logic [DATA_W-1:0] h2,
    output logic [DATA_W-1:0] x,
    output logic              in_range
);

    localparam int W = Y_W + 2;
    localparam logic signed [W-1:0] T1    = W'(TAP1);
    localparam logic signed [W-1:0] T2    = W'(TAP2);
    localparam logic signed [W-1:0] X_MAX = W'((1 << DATA_W) - 1);

    logic signed [W-1:0] y_s;
    logic signed [W-1:0] h1_s;
    logic signed [W-1:0] h2_s;
    logic signed [W-1:0] r;

    assign y_s  = $signed({2'b00, y});
    assign h1_s = $signed({{(W - DATA_W){1'b0}}, h1});
    assign h2_s = $signed({{(W - DATA_W){1'b0}}, h2});
    assign r    = y_s - T1 * h1_s - T2 * h2_s;

    assign in_range = !r[W-1] && (r <= X_MAX);
    assign x        = r[DATA_W-1:0];

endmodule

// File: rtl/fir_deconv.sv
// Streaming deconvolver for the 1-2-1 FIR: valid/ready in and out,
// one-cycle latency, sticky error on out-of-range recovery.
module fir_deconv
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int Y_W    = Y_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [Y_W-1:0]    y_in,
    input  logic              y_valid,
    output logic              y_ready,
    output logic [DATA_W-1:0] x_out,
    output logic              x_valid,
    input  logic              x_ready,
    output logic              err,
    output logic [CNT_W-1:0]  count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_t              state;
    logic                rdy_en;
    logic [DATA_W-1:0]   h1;
    logic [DATA_W-1:0]   h2;
    logic [DATA_W-1:0]   x_p1;
    logic                vld_p1;
    logic                err_q;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   x_new;
    logic                in_range;
    logic                y_xfer;
    logic                x_xfer;

    fir_deconv_core #(
        .DATA_W (DATA_W),
        .Y_W    (Y_W)
    ) u_core (
        .y        (y_in),
        .h1       (h1),
        .h2       (h2),
        .x        (x_new),
        .in_range (in_range)
    );

    // rdy_en keeps y_ready low until the first edge after reset release.
    assign y_ready = rdy_en && (state != ST_ERR) && (!vld_p1 || x_ready);
    assign y_xfer  = y_valid && y_ready;
    assign x_xfer  = vld_p1 && x_ready;

    // Stage p0 -> p1: recovered sample registered, history advanced.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            rdy_en <= 1'b0;
            h1     <= '0;
            h2     <= '0;
            x_p1   <= '0;
            vld_p1 <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (clr) begin
                state  <= ST_IDLE;
                h1     <= '0;
                h2     <= '0;
                x_p1   <= '0;
                vld_p1 <= 1'b0;
                err_q  <= 1'b0;
                cnt    <= '0;
            end else begin
                if (x_xfer)
                    vld_p1 <= 1'b0;
                if (y_xfer) begin
                    if (in_range) begin
                        x_p1   <= x_new;
                        vld_p1 <= 1'b1;
                        h1     <= x_new;
                        h2     <= h1;
                        cnt    <= sat_inc(cnt);
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_ERR;
                        err_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign x_out   = x_p1;
    assign x_valid = vld_p1;
    assign err     = err_q;
    assign count   = cnt;

endmodule

// File: tb/tb_fir_deconv.sv
// Directed bench for fir_deconv: nominal stream, back-pressure, error
// entry/exit, clr priority, FIR chain round trip and async reset abort.
module tb_fir_deconv;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] y_in = '0;
    logic        y_valid = 1'b0;
    logic        y_ready;
    logic [7:0]  x_out;
    logic        x_valid;
    logic        x_ready = 1'b1;
    logic        err;
    logic [15:0] count;

    int checks = 0;
    int failures = 0;

    fir_deconv dut (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .y_in    (y_in),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .x_out   (x_out),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .err     (err),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] y);
        y_in    = y;
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    logic [15:0] yv [4] = '{16'd3, 16'd11, 16'd20, 16'd19};
    logic [7:0]  xv [4] = '{8'd3, 8'd5, 8'd7, 8'd0};

    initial begin
        // Reset held low: everything zero, y_ready low.
        #12;
        chk("rst_x_out", 32'(x_out), 0);
        chk("rst_x_valid", 32'(x_valid), 0);
        chk("rst_y_ready", 32'(y_ready), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_count", 32'(count), 0);
        reset = 1'b1;
        #1;
        chk("rdy_before_edge", 32'(y_ready), 0);
        tick();
        chk("rdy_after_edge", 32'(y_ready), 1);

        // Back-to-back nominal stream.
        x_ready = 1'b1;
        y_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            y_in = yv[i];
            tick();
            chk($sformatf("nom_x%0d", i), 32'(x_out), 32'(xv[i]));
            chk($sformatf("nom_v%0d", i), 32'(x_valid), 1);
        end
        y_valid = 1'b0;
        tick();
        chk("nom_drain_v", 32'(x_valid), 0);
        chk("nom_count", 32'(count), 4);
        chk("nom_err", 32'(err), 0);

        // Back-pressure for three cycles after the first output.
        do_clr();
        chk("clr_count", 32'(count), 0);
        y_in = yv[0];
        y_valid = 1'b1;
        tick();
        chk("bp_first", 32'(x_out), 3);
        x_ready = 1'b0;
        y_in = yv[1];
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_hold_x%0d", i), 32'(x_out), 3);
            chk($sformatf("bp_hold_v%0d", i), 32'(x_valid), 1);
            chk($sformatf("bp_rdy%0d", i), 32'(y_ready), 0);
        end
        x_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            y_in = yv[i];
            tick();
            chk($sformatf("bp_x%0d", i), 32'(x_out), 32'(xv[i]));
        end
        y_valid = 1'b0;
        tick();
        chk("bp_count", 32'(count), 4);

        // Out-of-range first sample, then recovery via clr.
        do_clr();
        send(16'd300);
        chk("hi_valid", 32'(x_valid), 0);
        chk("hi_err", 32'(err), 1);
        chk("hi_rdy", 32'(y_ready), 0);
        tick();
        chk("hi_err_sticky", 32'(err), 1);
        chk("hi_rdy_sticky", 32'(y_ready), 0);
        chk("hi_count", 32'(count), 0);
        do_clr();
        chk("hi_clr_err", 32'(err), 0);
        send(16'd3);
        chk("hi_rec_x", 32'(x_out), 3);
        chk("hi_rec_v", 32'(x_valid), 1);
        chk("hi_rec_err", 32'(err), 0);

        // Negative result, then clr beating a simultaneous y transfer.
        do_clr();
        send(16'd3);
        chk("neg_x", 32'(x_out), 3);
        send(16'd0);
        chk("neg_valid", 32'(x_valid), 0);
        chk("neg_err", 32'(err), 1);
        chk("neg_count", 32'(count), 1);
        clr = 1'b1;
        y_in = 16'd3;
        y_valid = 1'b1;
        tick();
        clr = 1'b0;
        y_valid = 1'b0;
        chk("clrw_valid", 32'(x_valid), 0);
        chk("clrw_count", 32'(count), 0);
        chk("clrw_err", 32'(err), 0);
        send(16'd11);
        chk("clrw_hist_zero", 32'(x_out), 11);
        chk("clrw_count1", 32'(count), 1);

        // FIR chain round trip, including the filter's initial zero output.
        begin
            int x1 = 0;
            int x2 = 0;
            int xs [$];
            int ys [$];
            xs.push_back(0);
            ys.push_back(0);
            for (int i = 0; i < 200; i++) begin
                int xn = int'($urandom_range(0, 255));
                xs.push_back(xn);
                ys.push_back(xn + 2 * x1 + x2);
                x2 = x1;
                x1 = xn;
            end
            do_clr();
            x_ready = 1'b1;
            y_valid = 1'b1;
            for (int i = 0; i < ys.size(); i++) begin
                y_in = 16'(ys[i]);
                tick();
                chk($sformatf("chain%0d", i), 32'(x_out), 32'(xs[i]));
            end
            y_valid = 1'b0;
            tick();
            chk("chain_count", 32'(count), 32'(xs.size()));
            chk("chain_err", 32'(err), 0);
        end

        // Asynchronous reset with an output pending.
        do_clr();
        x_ready = 1'b0;
        send(16'd7);
        chk("ar_pending", 32'(x_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_x_out", 32'(x_out), 0);
        chk("ar_x_valid", 32'(x_valid), 0);
        chk("ar_count", 32'(count), 0);
        chk("ar_y_ready", 32'(y_ready), 0);
        chk("ar_err", 32'(err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
